// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//
// Purpose : Shared types and constants for the 5-stage RISC-V core that the
//           load-use hazard unit relies on: RV32I base opcodes, the hazard
//           sequencer state type and the width of its cycle down-counter.
//
// Contents:
//   OPCODE_*          7-bit RV32I major opcodes (instr[6:0])
//   hazard_state_t    HZ_RUN / HZ_LOAD_STALL / HZ_FLUSH
//   HZ_CNT_W          width of the stall/flush remaining-cycle counter
//   HZ_CNT_MAX        largest value the counter can hold
//   hz_reload()       converts a total cycle count into a counter reload value
// -----------------------------------------------------------------------------
package core_pkg;

    // RV32I major opcodes.
    localparam logic [6:0] OPCODE_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b001_0011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPCODE_STORE  = 7'b010_0011;
    localparam logic [6:0] OPCODE_OP     = 7'b011_0011;
    localparam logic [6:0] OPCODE_LUI    = 7'b011_0111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPCODE_JALR   = 7'b110_0111;
    localparam logic [6:0] OPCODE_JAL    = 7'b110_1111;

    // Hazard sequencer state, exported on hz_state_op for debug.
    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_LOAD_STALL = 2'd1,
        HZ_FLUSH      = 2'd2
    } hazard_state_t;

    // The counter holds the cycles still to go after the current one, so a
    // 3-bit counter covers sequences of up to 7 cycles in total.
    localparam int unsigned HZ_CNT_W   = 3;
    localparam int unsigned HZ_CNT_MAX = (1 << HZ_CNT_W) - 1;

    // Total sequence length -> counter value loaded in the first cycle.
    // The first cycle is the one that raises the request, hence the -1.
    function automatic logic [HZ_CNT_W-1:0] hz_reload(input int unsigned total_cycles);
        int unsigned rem;
        rem = (total_cycles > 0) ? total_cycles - 1 : 0;
        return HZ_CNT_W'(rem);
    endfunction

endpackage : core_pkg

// File: rtl/load_use_hazard_unit_rs_use_decode.sv
// -----------------------------------------------------------------------------
// rs_use_decode
//
// Purpose : Combinational decode of which source-register fields an RV32I
//           instruction actually reads. Formats without rs1/rs2 still carry
//           bits in those positions (immediates), and comparing them against a
//           load destination would raise false load-use stalls.
//
// Ports   :
//   opcode_i    in  7  opcode (instr[6:0]) of the instruction in ID
//   rs1_used_o  out 1  instruction reads rs1
//   rs2_used_o  out 1  instruction reads rs2
// -----------------------------------------------------------------------------
module rs_use_decode
    import core_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       rs1_used_o,
    output logic       rs2_used_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves it unassigned; an unassigned path in always_comb infers a latch.
        rs1_used_o = 1'b0;
        rs2_used_o = 1'b0;
        case (opcode_i)
            OPCODE_OP: begin
                rs1_used_o = 1'b1;
                rs2_used_o = 1'b1;
            end
            OPCODE_STORE,
            OPCODE_BRANCH: begin
                rs1_used_o = 1'b1;
                rs2_used_o = 1'b1;
            end
            OPCODE_OPIMM,
            OPCODE_LOAD,
            OPCODE_JALR: begin
                rs1_used_o = 1'b1;
            end
            // LUI, AUIPC, JAL and anything unrecognised read no registers.
            default: begin
                rs1_used_o = 1'b0;
                rs2_used_o = 1'b0;
            end
        endcase
    end

endmodule : rs_use_decode

// File: rtl/load_use_hazard_unit.sv
// -----------------------------------------------------------------------------
// load_use_hazard_unit
//
// Purpose : ID-stage stall/flush sequencer for the 5-stage RISC-V core. Decides
//           whether the ID instruction may enter ID/EX and drives the hold,
//           bubble and flush controls of PC, IF/ID and ID/EX. Three sources:
//             - load-use hazards that forwarding cannot cover,
//             - control flushes from FWD_Control (flush_en_op),
//             - data-memory wait states, which freeze the whole pipe.
//           Priority each cycle: reset > dmem stall > flush > load-use.
//
// Parameters:
//   LOAD_STALL_CYCLES  total cycles ID is held per load-use hazard (1..7)
//   FLUSH_CYCLES       total cycles of IF/ID flush per flush request (1..7)
//
// Ports   :
//   clk                 in  1   core clock, all state on the rising edge
//   reset               in  1   synchronous, active-high
//   id_instr_opcode_ip  in  7   opcode of the instruction in ID
//   id_rs1_ip           in  5   rs1 field of the instruction in ID
//   id_rs2_ip           in  5   rs2 field of the instruction in ID
//   ex_mem_read_ip      in  1   ID/EX instruction is a load
//   ex_dest_ip          in  5   destination register of the ID/EX instruction
//   flush_en_ip         in  1   flush request from FWD_Control
//   dmem_stall_ip       in  1   data memory not ready, freeze everything
//   pc_hold_op          out 1   PC keeps its value
//   if_id_hold_op       out 1   IF/ID keeps its value
//   if_id_flush_op      out 1   IF/ID is loaded with a NOP
//   id_ex_bubble_op     out 1   ID/EX is loaded with a NOP
//   global_hold_op      out 1   every pipeline register holds
//   hz_state_op         out 2   current sequencer state (debug)
//
// Build option HAZARD_PERF_CNT_EN adds two saturating 32-bit counters:
//   load_stall_cnt_op   out 32  cycles with a load-use bubble
//   flush_cnt_op        out 32  cycles with a flush bubble
// -----------------------------------------------------------------------------
module load_use_hazard_unit
    import core_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES      = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [6:0]    id_instr_opcode_ip,
    input  logic [4:0]    id_rs1_ip,
    input  logic [4:0]    id_rs2_ip,
    input  logic          ex_mem_read_ip,
    input  logic [4:0]    ex_dest_ip,
    input  logic          flush_en_ip,
    input  logic          dmem_stall_ip,
    output logic          pc_hold_op,
    output logic          if_id_hold_op,
    output logic          if_id_flush_op,
    output logic          id_ex_bubble_op,
    output logic          global_hold_op,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]   load_stall_cnt_op,
    output logic [31:0]   flush_cnt_op,
`endif
    output hazard_state_t hz_state_op
);

    localparam logic [HZ_CNT_W-1:0] LOAD_RELOAD  = hz_reload(LOAD_STALL_CYCLES);
    localparam logic [HZ_CNT_W-1:0] FLUSH_RELOAD = hz_reload(FLUSH_CYCLES);

    hazard_state_t         state_q, state_d;
    logic [HZ_CNT_W-1:0]   cnt_q, cnt_d;

    logic rs1_used;
    logic rs2_used;
    logic hazard;

    // ------------------------------------------------------------------------
    // Load-use detection
    // ------------------------------------------------------------------------
    rs_use_decode u_rs_use_decode (
        .opcode_i   (id_instr_opcode_ip),
        .rs1_used_o (rs1_used),
        .rs2_used_o (rs2_used)
    );

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign hazard = ex_mem_read_ip && (ex_dest_ip != 5'd0) &&
                    ((rs1_used && (id_rs1_ip == ex_dest_ip)) ||
                     (rs2_used && (id_rs2_ip == ex_dest_ip)));

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pc_hold_op      = 1'b0;
        if_id_hold_op   = 1'b0;
        if_id_flush_op  = 1'b0;
        id_ex_bubble_op = 1'b0;
        global_hold_op  = 1'b0;

        if (reset) begin
            // Outputs stay 0; the register process performs the actual reset.
            state_d = HZ_RUN;
            cnt_d   = '0;
        end else if (dmem_stall_ip) begin
            // Freeze: state and counter keep their values, and the frozen
            // upstream logic re-presents flush/hazard once memory is ready.
            global_hold_op = 1'b1;
        end else if (flush_en_ip) begin
            // A flush wins over a load stall in progress: the stalled
            // instruction is on the wrong path anyway.
            if_id_flush_op  = 1'b1;
            id_ex_bubble_op = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = HZ_FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = HZ_RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                HZ_RUN: begin
                    if (hazard) begin
                        pc_hold_op      = 1'b1;
                        if_id_hold_op   = 1'b1;
                        id_ex_bubble_op = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = HZ_LOAD_STALL;
                            cnt_d   = LOAD_RELOAD;
                        end
                    end
                end

                HZ_LOAD_STALL: begin
                    // ID/EX already holds a bubble, so hazard is not re-checked.
                    pc_hold_op      = 1'b1;
                    if_id_hold_op   = 1'b1;
                    id_ex_bubble_op = 1'b1;
                    if (cnt_q <= 1) begin
                        state_d = HZ_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end

                HZ_FLUSH: begin
                    if_id_flush_op  = 1'b1;
                    id_ex_bubble_op = 1'b1;
                    if (cnt_q <= 1) begin
                        state_d = HZ_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_d = HZ_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge value of every other; blocking would create ordering races.
        if (reset) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz_state_op = state_q;

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
    // A bubble without IF/ID flush can only come from a load-use stall; a
    // bubble with flush is always flush-driven. Neither is asserted during
    // reset or a memory freeze, so no extra qualification is needed.
    logic        load_bubble;
    logic        flush_bubble;
    logic [31:0] load_stall_cnt_q;
    logic [31:0] flush_cnt_q;

    assign load_bubble  = id_ex_bubble_op && !if_id_flush_op;
    assign flush_bubble = id_ex_bubble_op &&  if_id_flush_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            load_stall_cnt_q <= '0;
            flush_cnt_q      <= '0;
        end else begin
            if (load_bubble && (load_stall_cnt_q != 32'hFFFF_FFFF)) begin
                load_stall_cnt_q <= load_stall_cnt_q + 32'd1;
            end
            if (flush_bubble && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign load_stall_cnt_op = load_stall_cnt_q;
    assign flush_cnt_op      = flush_cnt_q;
`endif

endmodule : load_use_hazard_unit

// File: doc/load_use_hazard_unit.md
# load_use_hazard_unit

Stall/flush sequencer for the 5-stage RISCV core. It sits in the ID stage, directly upstream of `FWD_Control`, and decides whether the ID-stage instruction may enter ID/EX. It handles three cases: load-use hazards, which forwarding cannot cover; control flushes raised by `FWD_Control` (`flush_en_op`); and data-memory wait states. It drives hold, bubble and flush controls for the PC, IF/ID and ID/EX registers.

## Interface
- `LOAD_STALL_CYCLES`, default 1: total cycles ID is held per load-use hazard (range 1–7).
- `FLUSH_CYCLES`, default 1: total cycles of IF/ID flush per flush request (range 1–7).
- `clk`  in  1  core clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `id_instr_opcode_ip`  in  7  opcode of the instruction in ID.
- `id_rs1_ip` / `id_rs2_ip`  in  5 each  source registers of the instruction in ID.
- `ex_mem_read_ip`  in  1  the ID/EX instruction is a load.
- `ex_dest_ip`  in  5  destination register of the ID/EX instruction.
- `flush_en_ip`  in  1  flush request (from `FWD_Control.flush_en_op`).
- `dmem_stall_ip`  in  1  data memory not ready; the whole pipe must freeze.
- `pc_hold_op`  out  1  PC keeps its value at the next edge.
- `if_id_hold_op`  out  1  IF/ID keeps its value.
- `if_id_flush_op`  out  1  IF/ID is loaded with a NOP.
- `id_ex_bubble_op`  out  1  ID/EX is loaded with a NOP (`NO_WRITEBACK`, no mem op).
- `global_hold_op`  out  1  freeze every pipeline register.
- `hz_state_op`  out  `hazard_state_t`  current state, for debug.

## Operation
- **rs usage (decode):**
  - rs1 is used by `OPCODE_OP`, `OPCODE_OPIMM`, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by `OPCODE_OP`, STORE and BRANCH.
  - LUI, AUIPC, JAL and unknown opcodes use neither.
- **hazard** = `ex_mem_read_ip` && `ex_dest_ip`≠0 && ((rs1 used && rs1==`ex_dest_ip`) || (rs2 used && rs2==`ex_dest_ip`)).
- **States:** `HZ_RUN`, `HZ_LOAD_STALL`, `HZ_FLUSH`. A 3-bit down-counter `cnt` holds the remaining cycles.
- **Priority, evaluated each cycle:** `reset` > `dmem_stall_ip` > `flush_en_ip` > load-use.
- **`reset`:** state←`HZ_RUN`, `cnt`←0, and all outputs are forced to 0 in that cycle.
- **`dmem_stall_ip`=1:**
  - Outputs: `global_hold_op`=1, all other outputs 0.
  - State and `cnt` do not change.
  - `flush_en_ip` and hazard are not evaluated; the source stays frozen and re-presents them after the stall.
- **`flush_en_ip`=1, in any state:**
  - Outputs: `if_id_flush_op`=1, `id_ex_bubble_op`=1, no holds.
  - If `FLUSH_CYCLES`>1: next state `HZ_FLUSH` with `cnt`=`FLUSH_CYCLES`−1; otherwise next state `HZ_RUN`.
  - A flush aborts a load stall in progress, because the stalled instruction is wrong-path.
- **`HZ_FLUSH`:**
  - Outputs: `if_id_flush_op`=1, `id_ex_bubble_op`=1.
  - `cnt` decrements each cycle; the state exits to `HZ_RUN` in the cycle `cnt`==1.
  - A new `flush_en_ip` reloads `cnt`.
- **`HZ_RUN` with hazard:**
  - Outputs: `pc_hold_op`, `if_id_hold_op` and `id_ex_bubble_op` all 1.
  - If `LOAD_STALL_CYCLES`>1: next state `HZ_LOAD_STALL` with `cnt`=`LOAD_STALL_CYCLES`−1.
- **`HZ_LOAD_STALL`:**
  - Same three outputs at 1.
  - Hazard detection is masked because ID/EX now holds a bubble.
  - `cnt` decrements; the state exits to `HZ_RUN` in the cycle `cnt`==1.
- **`HZ_RUN` without hazard:** all outputs are 0.

## Timing
- All outputs are combinational from state plus inputs, valid in the same cycle; registers update at the next `clk` edge.
- Stall length is exactly `LOAD_STALL_CYCLES` cycles, counting the detection cycle.
- Flush length is exactly `FLUSH_CYCLES` cycles.
- Stall and flush cycles extend by the number of `dmem_stall_ip` cycles that occur inside them.
- Load-use after a stall: the dependent instruction reaches EX with the load in MEM/WB, where `FWD_Control` selects `WB_RESULT_SELECT`.
- `if_id_hold_op` and `if_id_flush_op` are never both 1.
- `global_hold_op` is never 1 together with any other output.

## Configuration
- **`HAZARD_PERF_CNT_EN` defined:**
  - Adds outputs `load_stall_cnt_op` [31:0] and `flush_cnt_op` [31:0], both reset to 0.
  - They increment once per cycle with `id_ex_bubble_op` due to load-use and due to flush, respectively.
  - They saturate at 32'hFFFF_FFFF.
  - They do not count while `global_hold_op` is 1.
- **Not defined:** the ports and counters are absent and there is no behavioural difference otherwise.

## Structure
- `hazard_state_t` (`HZ_RUN`, `HZ_LOAD_STALL`, `HZ_FLUSH`) lives in `CORE_PKG`; opcodes are reused from `CORE_PKG`.
- Sub-module `rs_use_decode` (combinational): maps opcode to `rs1_used` and `rs2_used`.

## Test plan
- **Load-use (`LOAD_STALL_CYCLES`=1):** `ex_mem_read_ip`=1, `ex_dest_ip`=5, ID is `OPCODE_OP` with rs2=5 → exactly 1 cycle of hold+bubble, then all outputs 0.
- **Non-hazards:** `ex_dest_ip`=0, or ID is LUI with rs1 field = `ex_dest_ip`, or `OPCODE_OPIMM` with rs2 field = `ex_dest_ip` → no stall.
- **Flush aborts stall (`LOAD_STALL_CYCLES`=3):** `flush_en_ip` in the 2nd stall cycle → flush+bubble that cycle, holds drop, state returns to `HZ_RUN` (`FLUSH_CYCLES`=1).
- **Memory stall inside flush (`FLUSH_CYCLES`=2):** `dmem_stall_ip` held 3 cycles in the middle of the flush → `global_hold_op` only during those 3 cycles, flush spans 5 cycles total.
- **Reset mid-stall:** `reset` in the 2nd cycle of `HZ_LOAD_STALL` → outputs 0 that cycle, state is `HZ_RUN` next cycle.
- **Perf counters (`HAZARD_PERF_CNT_EN`):** 3 load-use stalls + 2 flushes → `load_stall_cnt_op`=3, `flush_cnt_op`=2. A preloaded 32'hFFFF_FFFF stays saturated.
